// File: rtl/sr_latch_driver.sv
// Drives non-overlapping S/R pulses into an external SR latch and confirms each
// command through the synchronized Q feedback, reporting done or err.
module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int DEAD_W  = 2,
  parameter int TIMEOUT = 8,
  parameter int CW      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic S,
  output logic R,
  input  logic q_fb,
  output logic done,
  output logic err,
  output logic busy
);

  // q_sync cannot reflect a pulse until the third cycle after the handshake, so a
  // very short pulse gets a feedback window stretched to at least reach that cycle.
  localparam int MIN_WAIT = 3 - PULSE_W;
  localparam int WAIT_LEN = (TIMEOUT > MIN_WAIT) ? TIMEOUT : MIN_WAIT;

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_LEN - 1);
  localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_W - 1);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_FB, DEAD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          target;
  logic          q_meta;
  logic          q_sync;

  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta <= 1'b0;
      q_sync <= 1'b0;
    end else begin
      q_meta <= q_fb;
      q_sync <= q_meta;
    end
  end

  // S and R are only ever loaded from cmd_set and its complement, so they can never both be high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      target <= 1'b0;
      S      <= 1'b0;
      R      <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            target <= cmd_set;
            cnt    <= '0;
            S      <= cmd_set;
            R      <= !cmd_set;
            state  <= PULSE;
          end
        end
        PULSE: begin
          if (cnt == PULSE_LAST) begin
            S     <= 1'b0;
            R     <= 1'b0;
            cnt   <= '0;
            state <= WAIT_FB;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_FB: begin
          // A match on the last allowed cycle wins over the timeout.
          if (q_sync == target) begin
            done  <= 1'b1;
            cnt   <= '0;
            state <= DEAD;
          end else if (cnt == WAIT_LAST) begin
            err   <= 1'b1;
            cnt   <= '0;
            state <= DEAD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DEAD: begin
          if (cnt == DEAD_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          S     <= 1'b0;
          R     <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: a default instance and a minimum-timing instance share
// one behavioural SR latch; each command is checked against a cycle timeline model.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sel;
  logic cmd_valid;
  logic cmd_set;
  logic use_latch;
  logic q_drive;
  logic latch_q = 1'b0;
  logic q_fb;

  logic ready0, s0, r0, done0, err0, busy0;
  logic ready1, s1, r1, done1, err1, busy1;
  logic v0, v1;
  logic s_m, r_m, done_m, err_m, ready_m, busy_m;

  int checks = 0;
  int passes = 0;

  assign v0 = cmd_valid & ~sel;
  assign v1 = cmd_valid & sel;
  assign q_fb = use_latch ? latch_q : q_drive;

  assign s_m     = sel ? s1 : s0;
  assign r_m     = sel ? r1 : r0;
  assign done_m  = sel ? done1 : done0;
  assign err_m   = sel ? err1 : err0;
  assign ready_m = sel ? ready1 : ready0;
  assign busy_m  = sel ? busy1 : busy0;

  sr_latch_driver u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_set(cmd_set), .cmd_ready(ready0),
    .S(s0), .R(r0), .q_fb(q_fb), .done(done0), .err(err0), .busy(busy0)
  );

  sr_latch_driver #(.PULSE_W(1), .DEAD_W(1), .TIMEOUT(1), .CW(8)) u_dut_min (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_set(cmd_set), .cmd_ready(ready1),
    .S(s1), .R(r1), .q_fb(q_fb), .done(done1), .err(err1), .busy(busy1)
  );

  // Ideal SR latch: reacts at once to the selected driver's S/R.
  always @(s_m or r_m) begin
    if (s_m) latch_q = 1'b1;
    else if (r_m) latch_q = 1'b0;
  end

  always @(negedge clk) begin
    checks++;
    if ((s0 && r0) || (s1 && r1))
      $display("[TB] FAIL no_overlap: S0,R0,S1,R1=%b%b%b%b required no S&&R", s0, r0, s1, r1);
    else
      passes++;
  end

  // One command from cycle 0 (handshake at the edge ending it) until the cycle before
  // cmd_ready returns. mode: 0 = latch feedback, 1 = random q_fb, 2 = q_fb stuck at 0.
  // vmode: valid during busy cycles 0 = low, 1 = random, 2 = held high.
  task automatic run_cmd(input bit target, input int mode, input int vmode);
    bit qv[64];
    int p, d, t, l, x;
    bit matched;
    logic [5:0] exp_v, got_v;
    p = sel ? 1 : 4;
    d = sel ? 1 : 2;
    t = sel ? 1 : 8;
    l = (t > 3 - p) ? t : 3 - p;
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0:       qv[i] = (i == 0) ? latch_q : target;
        1:       qv[i] = ($urandom_range(0, 3) == 0) ? target : !target;
        default: qv[i] = 1'b0;
      endcase
    end
    // q_sync during cycle f shows q_fb from cycle f-2.
    matched = 1'b0;
    x = p + l + 1;
    for (int f = p + 1; f <= p + l; f++) begin
      if (!matched && qv[f-2] == target) begin
        matched = 1'b1;
        x = f + 1;
      end
    end
    use_latch = (mode == 0);
    cmd_valid = 1'b1;
    cmd_set   = target;
    q_drive   = qv[0];
    for (int k = 0; k < x + d; k++) begin
      if (k > 0) begin
        q_drive = qv[k];
        case (vmode)
          0:       cmd_valid = 1'b0;
          1:       cmd_valid = 1'($urandom_range(0, 1));
          default: cmd_valid = 1'b1;
        endcase
        cmd_set = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      exp_v = {(k >= 1 && k <= p && target), (k >= 1 && k <= p && !target),
               (k == x && matched), (k == x && !matched), (k == 0), (k != 0)};
      got_v = {s_m, r_m, done_m, err_m, ready_m, busy_m};
      checks++;
      if (got_v !== exp_v)
        $display("[TB] FAIL cmd_cycle%0d (set=%0d mode=%0d inst=%0d): S,R,done,err,ready,busy=%b required %b",
                 k, target, mode, sel, got_v, exp_v);
      else
        passes++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (mode == 0) begin
      checks++;
      if (latch_q !== target)
        $display("[TB] FAIL latch_q: got %b required %b", latch_q, target);
      else
        passes++;
    end
  endtask

  task automatic test_reset();
    logic [11:0] got_v;
    rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_set = 1'b0;
    use_latch = 1'b1; q_drive = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got_v = {s0, r0, done0, err0, ready0, busy0, s1, r1, done1, err1, ready1, busy1};
    checks++;
    if (got_v !== 12'b000010_000010)
      $display("[TB] FAIL reset_outputs: got %b required %b", got_v, 12'b000010_000010);
    else
      passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_v = {s0, r0, done0, err0, ready0, busy0, s1, r1, done1, err1, ready1, busy1};
    checks++;
    if (got_v !== 12'b000010_000010)
      $display("[TB] FAIL after_release: got %b required %b", got_v, 12'b000010_000010);
    else
      passes++;
  endtask

  task automatic test_set_clear();
    sel = 1'b0;
    run_cmd(1'b1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    run_cmd(1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    sel = 1'b0;
    run_cmd(1'b1, 2, 0);
    run_cmd(1'b0, 2, 1);
  endtask

  task automatic test_back_to_back();
    bit next_t;
    sel = 1'b0;
    next_t = !latch_q;
    for (int i = 0; i < 6; i++) begin
      run_cmd(next_t, 0, 2);
      next_t = !next_t;
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [5:0] got_v;
    sel = 1'b0; use_latch = 1'b1;
    cmd_valid = 1'b1; cmd_set = !latch_q;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    got_v = {s0, r0, done0, err0, ready0, busy0};
    checks++;
    if (got_v !== 6'b000010)
      $display("[TB] FAIL reset_async: S,R,done,err,ready,busy=%b required 000010", got_v);
    else
      passes++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got_v = {s0, r0, done0, err0, ready0, busy0};
      checks++;
      if (got_v !== 6'b000010)
        $display("[TB] FAIL reset_hold%0d: S,R,done,err,ready,busy=%b required 000010", i, got_v);
      else
        passes++;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_cmd(!latch_q, 0, 0);
    run_cmd(!latch_q, 0, 0);
  endtask

  task automatic test_min_params();
    sel = 1'b1;
    run_cmd(!latch_q, 0, 0);
    run_cmd(!latch_q, 0, 0);
    run_cmd(latch_q, 0, 1);
    run_cmd(1'b1, 2, 0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < 14; i++) begin
        run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_timeout();
    test_back_to_back();
    test_reset_mid_pulse();
    test_min_params();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
